ncc_job_scheduler: RTL and testbench

Sequencing controller for the 16x16 NCC processing-element array. On a start command it loads one 256-pixel descriptor into the array as 64 packed 32-bit words, then streams NUM_WINDOWS candidate windows through it. For each window it waits for the array score to settle, then keeps a running maximum of score and window index. It sits between the upstream fetch logic (descriptor/window streams) and the array, and reports one best-match result per job to the host side.

---
 rtl/ncc_job_scheduler.sv | 139 +++++++++++++
 tb/tb_ncc_job_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_job_scheduler.sv
// Job sequencer for the 16x16 NCC array: descriptor load, window stream, best match.
// Optional early exit on a score threshold when NCC_SCHED_THRESH_EN is defined.
module ncc_job_scheduler #(
  parameter int DESC_WORDS    = 64,
  parameter int NUM_WINDOWS   = 150,
  parameter int SCORE_W       = 64,
  parameter int IDX_W         = 9,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  input  logic               desc_in_valid,
  output logic               desc_in_ready,
  input  logic [31:0]        desc_in_data,
  input  logic               win_in_valid,
  output logic               win_in_ready,
  output logic               arr_desc_load,
  output logic [31:0]        arr_desc_data,
  output logic               arr_win_load,
  input  logic [SCORE_W-1:0] arr_score,
`ifdef NCC_SCHED_THRESH_EN
  input  logic [SCORE_W-1:0] thresh,
`endif
  output logic               done,
  output logic               result_valid,
  output logic [SCORE_W-1:0] best_score,
  output logic [IDX_W-1:0]   best_index
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DESC   = 3'd1;
  localparam logic [2:0] WIN    = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int DCW = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  logic [2:0]       state;
  logic [DCW-1:0]   desc_cnt;
  logic [IDX_W-1:0] win_cnt;
  logic [SCW-1:0]   settle_cnt;

  logic desc_last;
  logic win_last;
  logic settle_last;
  logic better;
  logic hit;

  assign desc_last   = desc_cnt == DCW'(DESC_WORDS - 1);
  assign win_last    = win_cnt == IDX_W'(NUM_WINDOWS - 1);
  assign settle_last = settle_cnt == '0;
  assign better      = arr_score > best_score;

`ifdef NCC_SCHED_THRESH_EN
  assign hit = arr_score >= thresh;
`else
  assign hit = 1'b0;
`endif

  // Ready is withheld under abort so a coincident handshake is never consumed.
  assign busy          = state != IDLE;
  assign desc_in_ready = (state == DESC) && !abort;
  assign win_in_ready  = (state == WIN) && !abort;
  assign arr_win_load  = win_in_ready && win_in_valid;
  assign done          = (state == DONE) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      desc_cnt      <= '0;
      win_cnt       <= '0;
      settle_cnt    <= '0;
      arr_desc_load <= 1'b0;
      arr_desc_data <= '0;
      result_valid  <= 1'b0;
      best_score    <= '0;
      best_index    <= '0;
    end else begin
      arr_desc_load <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              best_score   <= '0;
              best_index   <= '0;
              result_valid <= 1'b0;
              desc_cnt     <= '0;
              win_cnt      <= '0;
              state        <= DESC;
            end
          end
          DESC: begin
            if (desc_in_valid) begin
              arr_desc_data <= desc_in_data;
              arr_desc_load <= 1'b1;
              desc_cnt      <= desc_cnt + DCW'(1);
              if (desc_last)
                state <= WIN;
            end
          end
          WIN: begin
            if (win_in_valid) begin
              settle_cnt <= SCW'(SETTLE_CYCLES - 1);
              state      <= SETTLE;
            end
          end
          SETTLE: begin
            if (!settle_last) begin
              settle_cnt <= settle_cnt - SCW'(1);
            end else begin
              // Strict compare: ties keep the earlier window.
              if (hit || better) begin
                best_score <= arr_score;
                best_index <= win_cnt;
              end
              win_cnt <= win_cnt + IDX_W'(1);
              if (hit || win_last)
                state <= DONE;
              else
                state <= WIN;
            end
          end
          DONE: begin
            result_valid <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ncc_job_scheduler.sv
// Scoreboard bench for ncc_job_scheduler: directed jobs, abort and reset cases.
// A small array model returns per-window scores from a bench-owned table.
module tb_ncc_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        desc_in_valid;
  logic        desc_in_ready;
  logic [31:0] desc_in_data;
  logic        win_in_valid;
  logic        win_in_ready;
  logic        arr_desc_load;
  logic [31:0] arr_desc_data;
  logic        arr_win_load;
  logic [63:0] arr_score;
`ifdef NCC_SCHED_THRESH_EN
  logic [63:0] thresh;
`endif
  logic        done;
  logic        result_valid;
  logic [63:0] best_score;
  logic [8:0]  best_index;

  ncc_job_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .desc_in_valid (desc_in_valid),
    .desc_in_ready (desc_in_ready),
    .desc_in_data  (desc_in_data),
    .win_in_valid  (win_in_valid),
    .win_in_ready  (win_in_ready),
    .arr_desc_load (arr_desc_load),
    .arr_desc_data (arr_desc_data),
    .arr_win_load  (arr_win_load),
    .arr_score     (arr_score),
`ifdef NCC_SCHED_THRESH_EN
    .thresh        (thresh),
`endif
    .done          (done),
    .result_valid  (result_valid),
    .best_score    (best_score),
    .best_index    (best_index)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int dload_cnt = 0;
  int wseen;

  logic [63:0] sc [150];
  logic [63:0] es_q [$];
  int          ei_q [$];
  logic [31:0] dq [$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tfail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s got=timeout exp=event", nm);
  endtask

  // Array model: score for window k appears after its load edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wseen     <= 0;
      arr_score <= '0;
    end else if (start && !abort && !busy) begin
      wseen <= 0;
    end else if (arr_win_load) begin
      arr_score <= (wseen < 150) ? sc[wseen] : 64'd0;
      wseen     <= wseen + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && desc_in_valid && desc_in_ready)
      dq.push_back(desc_in_data);
  end

  // Monitor: pops expected values whenever the DUT presents an output.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (es_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done got=%0h/%0d exp=none", best_score, best_index);
      end else begin
        chk("best_score", best_score, es_q.pop_front());
        chk("best_index", 64'(best_index), 64'(ei_q.pop_front()));
      end
    end
    if (arr_desc_load) begin
      dload_cnt++;
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_desc_load got=%0h exp=none", arr_desc_data);
      end else begin
        chk("arr_desc_data", 64'(arr_desc_data), 64'(dq.pop_front()));
      end
    end
  end

  function automatic logic [31:0] dword(input int seed, input int i);
    return 32'(seed * 65537) ^ 32'(i * 32'h01030507);
  endfunction

  task automatic push_expect(input bit use_th, input logic [63:0] th);
    logic [63:0] bs;
    int bi;
    bs = '0;
    bi = 0;
    for (int w = 0; w < 150; w++) begin
      if (use_th && sc[w] >= th) begin
        bs = sc[w];
        bi = w;
        break;
      end
      if (sc[w] > bs) begin
        bs = sc[w];
        bi = w;
      end
    end
    es_q.push_back(bs);
    ei_q.push_back(bi);
  endtask

  task automatic wait_ready(input bit is_win, input string nm);
    int n;
    n = 0;
    while (!(is_win ? win_in_ready : desc_in_ready) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) tfail(nm);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int seed, input int abort_at, input bit toggle,
                         input bit busy_start, input int nwin);
    int d0;
    int l0;
    int n;
    bit bad;
    d0 = done_cnt;
    l0 = dload_cnt;
    pulse_start();
    chk("desc_ready_after_start", 64'(desc_in_ready), 64'd1);
    for (int i = 0; i < 64; i++) begin
      desc_in_data  = dword(seed, i);
      desc_in_valid = 1'b1;
      wait_ready(1'b0, "desc_ready_timeout");
      @(posedge clk);
      #1;
      desc_in_valid = 1'b0;
      if (toggle) begin
        @(posedge clk);
        #1;
      end
    end
    for (int w = 0; w < nwin; w++) begin
      if (busy_start && w == 5) start = 1'b1;
      win_in_valid = 1'b1;
      wait_ready(1'b1, "win_ready_timeout");
      if (w == abort_at) begin
        abort = 1'b1;
        #1;
        chk("abort_no_win_load", 64'(arr_win_load), 64'd0);
        chk("abort_no_win_ready", 64'(win_in_ready), 64'd0);
        @(posedge clk);
        #1;
        abort        = 1'b0;
        win_in_valid = 1'b0;
        start        = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_result_valid", 64'(result_valid), 64'd0);
        chk("abort_desc_loads", 64'(dload_cnt - l0), 64'd64);
        return;
      end
      @(posedge clk);
      #1;
      win_in_valid = 1'b0;
    end
    start = 1'b0;
    bad = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(negedge clk);
      #1;
      if (win_in_ready) bad = 1'b1;
      n++;
    end
    if (done_cnt == d0) begin
      tfail("done_timeout");
    end else begin
      @(negedge clk);
      #1;
      chk("result_valid", 64'(result_valid), 64'd1);
      chk("busy_after_done", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("done_once", 64'(done_cnt - d0), 64'd1);
      chk("desc_loads", 64'(dload_cnt - l0), 64'd64);
      chk("win_ready_after_last", 64'(bad), 64'd0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    desc_in_valid = 1'b0;
    desc_in_data  = '0;
    win_in_valid  = 1'b0;
    for (int w = 0; w < 150; w++) sc[w] = '0;
`ifdef NCC_SCHED_THRESH_EN
    thresh = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_best_score", best_score, 64'd0);
    chk("rst_best_index", 64'(best_index), 64'd0);
    chk("rst_desc_ready", 64'(desc_in_ready), 64'd0);
    chk("rst_arr_desc", {31'd0, arr_desc_load, arr_desc_data}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset after 10 descriptor words.
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      desc_in_data  = dword(1, i);
      desc_in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    desc_in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {busy, desc_in_ready, win_in_ready, arr_desc_load,
                           arr_win_load, done, result_valid}, 64'd0);
    chk("midrst_desc_data", 64'(arr_desc_data), 64'd0);
    dq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy_next", 64'(busy), 64'd0);

    // Job A: 5,9,9,3 then zeros; gapped descriptor; start held while busy.
    sc[0] = 64'd5;
    sc[1] = 64'd9;
    sc[2] = 64'd9;
    sc[3] = 64'd3;
    push_expect(1'b0, '0);
    run_job(2, -1, 1'b1, 1'b1, 150);

    // Abort during window 40.
    sc[20] = 64'd50;
    run_job(3, 40, 1'b0, 1'b0, 150);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", 64'(busy), 64'd0);
    chk("start_abort_idle_ready", 64'(desc_in_ready), 64'd0);

    // Fresh job: tie at 77 keeps window 10; last window is a boundary.
    for (int w = 0; w < 150; w++) sc[w] = '0;
    sc[10]  = 64'd77;
    sc[30]  = 64'd76;
    sc[149] = 64'd77;
    push_expect(1'b0, '0);
    run_job(4, -1, 1'b0, 1'b0, 150);

    // Full-width unsigned compare with the max at window 0.
    for (int w = 0; w < 150; w++) sc[w] = 64'(w);
    sc[0]   = 64'hFFFF_FFFF_FFFF_FFFE;
    sc[100] = 64'h8000_0000_0000_0000;
    push_expect(1'b0, '0);
    run_job(5, -1, 1'b0, 1'b0, 150);

`ifdef NCC_SCHED_THRESH_EN
    // Early exit at window 7.
    for (int w = 0; w < 150; w++) sc[w] = '0;
    sc[3]  = 64'd50;
    sc[7]  = 64'd120;
    sc[20] = 64'd200;
    thresh = 64'd100;
    push_expect(1'b1, thresh);
    run_job(6, -1, 1'b0, 1'b0, 8);
`endif

    chk("queue_drained", 64'(es_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
